out_ctl_multi: RTL and testbench

Parametrised, multi-channel successor to the single-pin output controller. It drives CH output pins, each from its own input bit, under a per-channel mode: immediate pass, delayed (stability-qualified) update, or hold. Each channel has its own down-counter that enforces a programmable stable-time before the output follows the input. A global force strobe provides the legacy "delay over" override. The block sits between the UART command/decode logic and the external pin drivers.

---
 rtl/out_ctl_multi.sv | 135 +++++++++++++
 tb/tb_out_ctl_multi.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/out_ctl_multi.sv
// -----------------------------------------------------------------------------
// out_ctl_multi
//
// Multi-channel output pin controller. Each of CH channels drives one
// registered output pin from its own input bit. Every channel has its own mode:
//   00 PASS  : the output follows the input with one clock of latency
//   01 DELAY : the output follows the input only after the input has differed
//              from the output for a programmable number of clocks
//   1x HOLD  : the output is frozen
// In DELAY mode the channel runs a two-state IDLE/WAIT machine with a
// down-counter. The counter is loaded from dly_val when a wait starts, so a
// later change of dly_val does not disturb a wait that is already running.
// A global force_upd strobe makes every DELAY channel take its input at once.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous reset, active high
//   mode       per-channel mode, bits [2i+1:2i] belong to channel i
//   dly_val    stable time in clocks, captured when a wait starts
//   force_upd  global strobe: DELAY channels update immediately
//   pin_in     per-channel input values
//   pin_out    registered output pins
//   busy       channel i is waiting for its input to be stable
//   upd        one-cycle flag, high in the first cycle pin_out[i] shows a
//              new value
// -----------------------------------------------------------------------------
module out_ctl_multi #(
  parameter int          CH       = 4,
  parameter int          CNT_W    = 16,
  parameter bit          RST_PASS = 1'b1,
  parameter logic [CH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2*CH-1:0]   mode,
  input  logic [CNT_W-1:0]  dly_val,
  input  logic              force_upd,
  input  logic [CH-1:0]     pin_in,
  output logic [CH-1:0]     pin_out,
  output logic [CH-1:0]     busy,
  output logic [CH-1:0]     upd
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] MODE_PASS  = 2'b00;
  localparam logic [1:0] MODE_DELAY = 2'b01;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [1:0]       ch_mode;
      logic             pin_q;
      logic             pin_d;
      state_e           state_q;
      state_e           state_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             upd_q;
      logic             upd_d;
      logic             in_differs;

      assign ch_mode    = mode[2*gi +: 2];
      assign in_differs = (pin_in[gi] != pin_q);

      // Next-state logic. PASS and HOLD both park the machine in IDLE with a
      // cleared counter, so switching a waiting channel out of DELAY aborts
      // the wait on that same edge.
      always_comb begin
        pin_d   = pin_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (ch_mode)
          MODE_PASS: begin
            pin_d   = pin_in[gi];
            state_d = S_IDLE;
            cnt_d   = '0;
          end
          MODE_DELAY: begin
            if (force_upd) begin
              pin_d   = pin_in[gi];
              state_d = S_IDLE;
              cnt_d   = '0;
            end else if (state_q == S_IDLE) begin
              if (in_differs) begin
                state_d = S_WAIT;
                cnt_d   = dly_val;
              end
            end else begin
              // The glitch check comes first: an input that has returned to
              // the output value cancels the wait even if the count expired.
              if (!in_differs) begin
                state_d = S_IDLE;
                cnt_d   = '0;
              end else if (cnt_q == '0) begin
                pin_d   = pin_in[gi];
                state_d = S_IDLE;
              end else begin
                cnt_d   = cnt_q - CNT_W'(1);
              end
            end
          end
          default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        endcase
      end

      assign upd_d = (pin_d != pin_q);

      always_ff @(posedge clk) begin
        if (rst) begin
          pin_q   <= RST_PASS ? pin_in[gi] : RST_VAL[gi];
          state_q <= S_IDLE;
          cnt_q   <= '0;
          upd_q   <= 1'b0;
        end else begin
          pin_q   <= pin_d;
          state_q <= state_d;
          cnt_q   <= cnt_d;
          upd_q   <= upd_d;
        end
      end

      assign pin_out[gi] = pin_q;
      assign busy[gi]    = (state_q == S_WAIT);
      assign upd[gi]     = upd_q;
    end
  endgenerate

endmodule

// File: tb/tb_out_ctl_multi.sv
module tb_out_ctl_multi;
  localparam int CH    = 4;
  localparam int CNT_W = 16;
  localparam logic [CH-1:0] RST_VAL1 = 4'b0110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic [2*CH-1:0]   mode = '0;
  logic [CNT_W-1:0]  dly_val = '0;
  logic              force_upd = 1'b0;
  logic [CH-1:0]     pin_in = '0;
  logic [CH-1:0]     po0, bz0, up0, po1, bz1, up1;

  out_ctl_multi #(.CH(CH), .CNT_W(CNT_W), .RST_PASS(1'b1), .RST_VAL(4'b0000)) u_dut0 (
    .clk(clk), .rst(rst), .mode(mode), .dly_val(dly_val), .force_upd(force_upd),
    .pin_in(pin_in), .pin_out(po0), .busy(bz0), .upd(up0));

  out_ctl_multi #(.CH(CH), .CNT_W(CNT_W), .RST_PASS(1'b0), .RST_VAL(RST_VAL1)) u_dut1 (
    .clk(clk), .rst(rst), .mode(mode), .dly_val(dly_val), .force_upd(force_upd),
    .pin_in(pin_in), .pin_out(po1), .busy(bz1), .upd(up1));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Reference model: a channel in DELAY remembers the edge number at which it
  // is due to take its input; any equal sample or force cancels the wait.
  logic [CH-1:0] m_out [2];
  logic [CH-1:0] m_busy[2];
  logic [CH-1:0] m_upd [2];
  int            m_due [2][CH];

  logic [6*CH-1:0] obs;
  assign obs = {po0, bz0, up0, po1, bz1, up1};

  function automatic logic [6*CH-1:0] exp_v();
    return {m_out[0], m_busy[0], m_upd[0], m_out[1], m_busy[1], m_upd[1]};
  endfunction

  task automatic tick();
    logic [CH-1:0] prev;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_out[k]  = (k == 0) ? pin_in : RST_VAL1;
        m_busy[k] = '0;
        m_upd[k]  = '0;
      end else begin
        prev = m_out[k];
        for (int i = 0; i < CH; i++) begin
          case (mode[2*i +: 2])
            2'b00: begin m_out[k][i] = pin_in[i]; m_busy[k][i] = 1'b0; end
            2'b01: begin
              if (force_upd) begin
                m_out[k][i] = pin_in[i]; m_busy[k][i] = 1'b0;
              end else if (!m_busy[k][i]) begin
                if (pin_in[i] != m_out[k][i]) begin
                  m_busy[k][i] = 1'b1;
                  m_due[k][i]  = cyc + int'(dly_val) + 1;
                end
              end else if (pin_in[i] == m_out[k][i]) begin
                m_busy[k][i] = 1'b0;
              end else if (cyc == m_due[k][i]) begin
                m_out[k][i] = pin_in[i]; m_busy[k][i] = 1'b0;
              end
            end
            default: m_busy[k][i] = 1'b0;
          endcase
        end
        m_upd[k] = m_out[k] ^ prev;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pin_in = 4'b1010; mode = '0;
    tick(); tick();
    vectors++;
    if (obs !== {4'b1010, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 4'b0000}) begin
      miscompares++;
      $display("FAIL reset_state got=%h exp=%h", obs, {4'b1010, 8'h00, 4'b0110, 8'h00});
    end
    rst = 1'b0; pin_in = '0;
    for (int j = 0; j < 3; j++) begin
      tick();
      vectors++;
      if (obs !== exp_v()) begin
        miscompares++;
        $display("FAIL reset_release cyc=%0d got=%h exp=%h", cyc, obs, exp_v());
      end
    end
  endtask

  task automatic test_delay_timing();
    mode = 8'b00_00_00_01; dly_val = 16'd5; pin_in = 4'b0001;
    for (int j = 0; j <= 7; j++) begin
      tick();
      vectors++;
      if (obs !== exp_v()) begin
        miscompares++;
        $display("FAIL delay5_model j=%0d got=%h exp=%h", j, obs, exp_v());
      end
      vectors++;
      if (j <= 5 && {po0[0], bz0[0], up0[0]} !== 3'b010) begin
        miscompares++;
        $display("FAIL delay5_wait j=%0d got=%b exp=010", j, {po0[0], bz0[0], up0[0]});
      end else if (j == 6 && {po0[0], bz0[0], up0[0]} !== 3'b101) begin
        miscompares++;
        $display("FAIL delay5_change got=%b exp=101", {po0[0], bz0[0], up0[0]});
      end else if (j == 7 && {po0[0], bz0[0], up0[0]} !== 3'b100) begin
        miscompares++;
        $display("FAIL delay5_after got=%b exp=100", {po0[0], bz0[0], up0[0]});
      end
    end
    dly_val = '0; pin_in = 4'b0000;
    for (int j = 0; j <= 1; j++) begin
      tick();
      vectors++;
      if ((j == 0 && {po0[0], bz0[0], up0[0]} !== 3'b110) ||
          (j == 1 && {po0[0], bz0[0], up0[0]} !== 3'b001)) begin
        miscompares++;
        $display("FAIL delay0 j=%0d got=%b", j, {po0[0], bz0[0], up0[0]});
      end
    end
  endtask

  task automatic test_glitch();
    mode = 8'b00_00_01_00; dly_val = 16'd10; pin_in = 4'b0010;
    for (int j = 0; j < 16; j++) begin
      if (j == 4) pin_in = 4'b0000;
      tick();
      vectors++;
      if (obs !== exp_v() || po0[1] !== 1'b0 || up0[1] !== 1'b0 || bz0[1] !== (j < 4)) begin
        miscompares++;
        $display("FAIL glitch j=%0d got=%h exp=%h busy1=%b", j, obs, exp_v(), bz0[1]);
      end
    end
  endtask

  task automatic test_mixed();
    logic hold3, dly1;
    mode = 8'b10_00_01_00; dly_val = 16'd3;
    hold3 = m_out[0][3]; dly1 = m_out[0][1];
    for (int c = 0; c < 24; c++) begin
      if (c % 2 == 0) pin_in = ~pin_in;
      tick();
      vectors++;
      if (obs !== exp_v() || po0[3] !== hold3 || po0[1] !== dly1) begin
        miscompares++;
        $display("FAIL mixed c=%0d got=%h exp=%h", c, obs, exp_v());
      end
    end
  endtask

  task automatic test_force();
    logic hold3;
    mode = 8'b10_01_00_00; dly_val = 16'd10;
    hold3 = m_out[0][3];
    pin_in = m_out[0] ^ 4'b1100;
    for (int j = 0; j < 4; j++) tick();
    vectors++;
    if (bz0[2] !== 1'b1 || obs !== exp_v()) begin
      miscompares++;
      $display("FAIL force_prewait got=%h exp=%h", obs, exp_v());
    end
    force_upd = 1'b1;
    tick();
    force_upd = 1'b0;
    vectors++;
    if (obs !== exp_v() || po0[2] !== pin_in[2] || bz0[2] !== 1'b0 ||
        up0[2] !== 1'b1 || po0[3] !== hold3) begin
      miscompares++;
      $display("FAIL force_apply got=%h exp=%h", obs, exp_v());
    end
  endtask

  task automatic test_reset_midwait();
    mode = '0; pin_in = 4'b0000;
    tick(); tick();
    mode = 8'b01_01_01_01; dly_val = 16'd6; pin_in = 4'b0001;
    for (int j = 0; j < 4; j++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (obs !== {4'b0001, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 4'b0000}) begin
      miscompares++;
      $display("FAIL reset_midwait got=%h exp=%h", obs, {4'b0001, 8'h00, 4'b0110, 8'h00});
    end
    for (int j = 0; j <= 7; j++) begin
      tick();
      vectors++;
      if (obs !== exp_v() ||
          (j <= 6 && {po1, bz1} !== {4'b0110, 4'b0111}) ||
          (j == 7 && {po1, bz1, up1} !== {4'b0001, 4'b0000, 4'b0111})) begin
        miscompares++;
        $display("FAIL restart_wait j=%0d got=%h exp=%h", j, obs, exp_v());
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 3) == 0) pin_in = 4'($urandom);
      dly_val   = CNT_W'($urandom_range(0, 5));
      force_upd = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
      vectors++;
      if (obs !== exp_v()) begin
        miscompares++;
        $display("FAIL random c=%0d got=%h exp=%h", c, obs, exp_v());
      end
    end
    rst = 1'b0; force_upd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_delay_timing();
    test_glitch();
    test_mixed();
    test_force();
    test_reset_midwait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
